// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally
// and loads the IF/ID register, honouring stall, branch redirect and halt.
//
// state  | meaning
// BOOT   | first cycle after reset; PC held, IF/ID bubble
// RUN    | fetching; branch_taken > stall > normal issue
// HALTED | halt opcode issued; PC held until a branch redirect
module fetch_stage #(
  parameter logic [7:0]         RESET_PC  = 8'h00,
  parameter int                 INSTR_W   = 16,
  parameter logic [3:0]         HALT_OP   = 4'hF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [7:0]         pc_out,
  input  logic [7:0]         pc_inc,
  output logic [7:0]         imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [7:0]         branch_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [7:0]         ifid_pc,
  output logic               ifid_valid,
  output logic               halted,
  output logic [7:0]         fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t state;
  logic   is_halt;

  assign imem_addr = pc_out;
  assign is_halt   = (imem_rdata[INSTR_W-1 -: 4] == HALT_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc_out      <= RESET_PC;
      ifid_instr  <= NOP_INSTR;
      ifid_pc     <= 8'h00;
      ifid_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 8'h00;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          ifid_instr <= NOP_INSTR;
          ifid_valid <= 1'b0;
        end
        RUN: begin
          if (branch_taken) begin
            pc_out     <= branch_target;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= pc_out;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            ifid_instr  <= imem_rdata;
            ifid_pc     <= pc_out;
            ifid_valid  <= 1'b1;
            fetch_count <= fetch_count + 8'd1;
            // the halt instruction itself issues; only the PC stops advancing
            if (is_halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              pc_out <= pc_inc;
            end
          end
        end
        HALTED: begin
          if (branch_taken) begin
            state      <= RUN;
            halted     <= 1'b0;
            pc_out     <= branch_target;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= pc_out;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pc_out, pc_inc, imem_addr, branch_target = 8'h00;
  logic [15:0] imem_rdata, ifid_instr;
  logic        stall = 1'b0, branch_taken = 1'b0;
  logic [7:0]  ifid_pc, fetch_count;
  logic        ifid_valid, halted;

  logic        rst2 = 1'b1, stall2 = 1'b0, br2 = 1'b0;
  logic [7:0]  tgt2 = 8'h00;
  logic [7:0]  pc_out2, pc_inc2, imem_addr2, ifid_pc2, fetch_count2;
  logic [15:0] imem_rdata2, ifid_instr2;
  logic        ifid_valid2, halted2;

  logic [15:0] mem [256];
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  assign pc_inc      = pc_out + 8'h01;
  assign imem_rdata  = mem[imem_addr];
  assign pc_inc2     = pc_out2 + 8'h01;
  assign imem_rdata2 = {8'h20, imem_addr2};

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .pc_inc(pc_inc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .reset(rst2), .pc_out(pc_out2), .pc_inc(pc_inc2),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .stall(stall2),
    .branch_taken(br2), .branch_target(tgt2),
    .ifid_instr(ifid_instr2), .ifid_pc(ifid_pc2), .ifid_valid(ifid_valid2),
    .halted(halted2), .fetch_count(fetch_count2)
  );

  // reference model state
  logic [7:0]  m_pc, m_ipc, m_cnt;
  logic [15:0] m_instr;
  logic        m_valid, m_boot, m_halt;

  function automatic void model_step(input logic rst, input logic st, input logic br,
                                     input logic [7:0] tgt);
    logic [15:0] ins;
    if (rst) begin
      m_pc = 8'h00; m_boot = 1; m_halt = 0; m_instr = 16'h0000;
      m_ipc = 8'h00; m_valid = 0; m_cnt = 8'h00;
    end else if (m_boot) begin
      m_boot = 0; m_instr = 16'h0000; m_valid = 0;
    end else if (br) begin
      m_ipc = m_pc; m_pc = tgt; m_instr = 16'h0000; m_valid = 0; m_halt = 0;
    end else if (st) begin
      // everything holds
    end else if (m_halt) begin
      m_instr = 16'h0000; m_valid = 0;
    end else begin
      ins = mem[m_pc];
      m_instr = ins; m_ipc = m_pc; m_valid = 1; m_cnt = m_cnt + 8'd1;
      if (ins[15:12] == 4'hF) m_halt = 1;
      else m_pc = m_pc + 8'd1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_total++; if (pc_out !== 8'h00) $display("FAIL reset_pc: got %h want 00", pc_out); else n_pass++;
    n_total++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifid_valid); else n_pass++;
    n_total++; if (ifid_instr !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", ifid_instr); else n_pass++;
    n_total++; if (ifid_pc !== 8'h00) $display("FAIL reset_ifid_pc: got %h want 00", ifid_pc); else n_pass++;
    n_total++; if ({halted, fetch_count} !== 9'h000) $display("FAIL reset_halt_cnt: got %b/%h want 0/00", halted, fetch_count); else n_pass++;
  endtask

  task automatic test_free_run();
    reset = 1'b0;
    tick();
    n_total++; if (ifid_valid !== 1'b0) $display("FAIL boot_bubble: valid got %b want 0", ifid_valid); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if (ifid_pc !== 8'(k) || ifid_instr !== 16'h1000 + 16'(k) || ifid_valid !== 1'b1 || fetch_count !== 8'(k + 1))
        $display("FAIL free_run[%0d]: got pc=%h instr=%h v=%b cnt=%h want pc=%h instr=%h v=1 cnt=%h",
                 k, ifid_pc, ifid_instr, ifid_valid, fetch_count, 8'(k), 16'h1000 + 16'(k), 8'(k + 1));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (pc_out !== 8'h05 || ifid_instr !== 16'h1004 || ifid_pc !== 8'h04 || fetch_count !== 8'h05)
        $display("FAIL stall_hold[%0d]: got pc=%h instr=%h ipc=%h cnt=%h want 05/1004/04/05",
                 k, pc_out, ifid_instr, ifid_pc, fetch_count);
      else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_total++;
    if (ifid_instr !== 16'h1005 || ifid_pc !== 8'h05 || fetch_count !== 8'h06)
      $display("FAIL stall_release: got %h/%h cnt=%h want 1005/05 cnt=06", ifid_instr, ifid_pc, fetch_count);
    else n_pass++;
  endtask

  task automatic test_branch_with_stall();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    n_total++;
    if (pc_out !== 8'h40 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || fetch_count !== 8'h06)
      $display("FAIL branch_redirect: got pc=%h v=%b instr=%h cnt=%h want 40/0/0000/06",
               pc_out, ifid_valid, ifid_instr, fetch_count);
    else n_pass++;
    tick();
    n_total++;
    if (ifid_instr !== 16'h1040 || ifid_pc !== 8'h40 || ifid_valid !== 1'b1)
      $display("FAIL branch_fetch: got %h/%h v=%b want 1040/40 v=1", ifid_instr, ifid_pc, ifid_valid);
    else n_pass++;
  endtask

  task automatic test_halt();
    branch_taken = 1'b1; branch_target = 8'h07;
    tick();
    branch_taken = 1'b0;
    tick();
    n_total++;
    if (ifid_instr !== 16'hF000 || ifid_pc !== 8'h07 || ifid_valid !== 1'b1 || halted !== 1'b1 || pc_out !== 8'h07)
      $display("FAIL halt_issue: got instr=%h ipc=%h v=%b h=%b pc=%h want F000/07/1/1/07",
               ifid_instr, ifid_pc, ifid_valid, halted, pc_out);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++;
      if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || halted !== 1'b1 || pc_out !== 8'h07)
        $display("FAIL halted_bubble[%0d]: got v=%b instr=%h h=%b pc=%h want 0/0000/1/07",
                 k, ifid_valid, ifid_instr, halted, pc_out);
      else n_pass++;
    end
    branch_taken = 1'b1; branch_target = 8'h10;
    tick();
    branch_taken = 1'b0;
    n_total++;
    if (pc_out !== 8'h10 || halted !== 1'b0 || ifid_valid !== 1'b0)
      $display("FAIL halt_resume: got pc=%h h=%b v=%b want 10/0/0", pc_out, halted, ifid_valid);
    else n_pass++;
    tick();
    n_total++;
    if (ifid_instr !== 16'h1010 || ifid_pc !== 8'h10 || ifid_valid !== 1'b1)
      $display("FAIL resume_fetch: got %h/%h v=%b want 1010/10 v=1", ifid_instr, ifid_pc, ifid_valid);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h55;
    tick();
    n_total++;
    if (pc_out !== 8'h00 || ifid_valid !== 1'b0 || fetch_count !== 8'h00 || halted !== 1'b0)
      $display("FAIL mid_reset: got pc=%h v=%b cnt=%h h=%b want 00/0/00/0", pc_out, ifid_valid, fetch_count, halted);
    else n_pass++;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick();
    n_total++;
    if (ifid_valid !== 1'b0 || pc_out !== 8'h00)
      $display("FAIL mid_reset_boot: got v=%b pc=%h want 0/00", ifid_valid, pc_out);
    else n_pass++;
    tick();
    n_total++;
    if (ifid_instr !== 16'h1000 || ifid_pc !== 8'h00 || ifid_valid !== 1'b1 || fetch_count !== 8'h01)
      $display("FAIL mid_reset_first: got %h/%h v=%b cnt=%h want 1000/00 v=1 cnt=01",
               ifid_instr, ifid_pc, ifid_valid, fetch_count);
    else n_pass++;
  endtask

  task automatic test_random();
    logic r, s, b;
    logic [7:0] t;
    for (int i = 0; i < 256; i++)
      mem[i] = {($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 12'($urandom)};
    r = 1'b1; s = 1'b0; b = 1'b0; t = 8'h00;
    for (int c = 0; c < 600; c++) begin
      reset = r; stall = s; branch_taken = b; branch_target = t;
      model_step(r, s, b, t);
      tick();
      n_total++;
      if (pc_out !== m_pc || imem_addr !== m_pc || ifid_instr !== m_instr || ifid_pc !== m_ipc ||
          ifid_valid !== m_valid || halted !== m_halt || fetch_count !== m_cnt)
        $display("FAIL random[%0d]: got pc=%h addr=%h instr=%h ipc=%h v=%b h=%b cnt=%h want pc=%h instr=%h ipc=%h v=%b h=%b cnt=%h",
                 c, pc_out, imem_addr, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count,
                 m_pc, m_instr, m_ipc, m_valid, m_halt, m_cnt);
      else n_pass++;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
    end
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    rst2 = 1'b0;
    tick();
    n_total++; if (ifid_valid2 !== 1'b0 || pc_out2 !== 8'hFE) $display("FAIL wrap_boot: got v=%b pc=%h want 0/FE", ifid_valid2, pc_out2); else n_pass++;
    e = 8'hFE;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++;
      if (ifid_pc2 !== e || ifid_instr2 !== {8'h20, e} || ifid_valid2 !== 1'b1 || halted2 !== 1'b0)
        $display("FAIL wrap[%0d]: got ipc=%h instr=%h v=%b h=%b want %h/%h v=1 h=0",
                 k, ifid_pc2, ifid_instr2, ifid_valid2, halted2, e, {8'h20, e});
      else n_pass++;
      e = e + 8'd1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[7] = 16'hF000;
    #1;
    test_reset();
    test_free_run();
    test_stall();
    test_branch_with_stall();
    test_halt();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage 8-bit pipeline.
- Owns the 8-bit program counter and drives it to the external 8-bit ripple incrementer (Add: A=pc_out, B=8'h01).
- Consumes the incrementer's sum as the sequential next PC and loads the IF/ID pipeline register.
- Honours stall and flush from the hazard detection unit and branch redirects from EX.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- INSTR_W, 16, instruction width.
- HALT_OP, 4'hF, opcode (instr[INSTR_W-1:INSTR_W-4]) that halts fetch.
- NOP_INSTR, 16'h0000, encoding inserted on bubbles and squashes.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- pc_out  output  8  current PC; feeds the incrementer A input and imem_addr.
- pc_inc  input  8  incrementer sum (pc_out+1, carry discarded).
- imem_addr  output  8  instruction memory address; equals pc_out.
- imem_rdata  input  INSTR_W  combinational instruction memory read data for imem_addr.
- stall  input  1  HDU stall: hold PC and IF/ID.
- branch_taken  input  1  EX redirect; acts as a flush.
- branch_target  input  8  redirect PC.
- ifid_instr  output  INSTR_W  IF/ID instruction register.
- ifid_pc  output  8  PC of ifid_instr.
- ifid_valid  output  1  ifid_instr is a real instruction.
- halted  output  1  fetch is in HALTED.
- fetch_count  output  8  count of instructions issued into IF/ID; wraps.

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high, and overrides everything.
- Reset values:
  - pc=RESET_PC
  - state=BOOT
  - ifid_instr=NOP_INSTR, ifid_pc=8'h00, ifid_valid=0
  - halted=0, fetch_count=0
- imem read is combinational and same-cycle: imem_addr=pc_out.
- pc_inc is sampled at the edge; adder settling fits within one cycle.
- State machine (BOOT, RUN, HALTED):
  - BOOT: lasts exactly one cycle after reset deasserts. PC held, IF/ID bubble. Next state is RUN unconditionally; stall and branch are ignored in BOOT.
  - RUN, priority order branch_taken > stall > normal:
    - branch_taken: pc<=branch_target; IF/ID<=bubble (NOP_INSTR, valid=0, ifid_pc<=pc); fetch_count unchanged. Applies even if stall=1.
    - stall (no branch): pc, IF/ID and fetch_count all hold.
    - normal: ifid_instr<=imem_rdata, ifid_pc<=pc, ifid_valid<=1, fetch_count<=fetch_count+1.
      - Opcode != HALT_OP: pc<=pc_inc.
      - Opcode == HALT_OP: the halt instruction still issues, pc holds, next state is HALTED.
  - HALTED: halted=1; pc holds.
    - No stall: IF/ID<=bubble.
    - stall: IF/ID holds.
    - branch_taken (older branch resolving): pc<=branch_target, IF/ID<=bubble, next state is RUN, halted<=0 next cycle.
- Width rules:
  - PC is 8 bits.
  - pc=8'hFF advances to 8'h00 via pc_inc; no trap.
  - fetch_count wraps 8'hFF to 8'h00.
- Reset mid-operation: every state and output returns to its reset value at the next edge, regardless of stall or branch_taken.
- No other outputs change on bubble cycles.

Test Plan:
- Reset then free-run, imem[i]=16'h1000+i, external Add connected:
  - Cycle 1 after reset is a bubble.
  - Then ifid_pc=00,01,02…, ifid_instr=1000,1001,1002…, ifid_valid=1.
  - fetch_count increments each cycle.
- Stall held 3 cycles while pc=05 → pc_out stays 05 and IF/ID holds 1004/04. After release, the next issue is 1005/05.
- branch_taken=1, branch_target=8'h40, with stall=1 in the same cycle:
  - Next cycle: pc_out=40, ifid_valid=0, ifid_instr=0000.
  - Following cycle: ifid_instr=imem[40], ifid_pc=40.
- imem[07]=16'hF000 → the F000 instruction issues with ifid_pc=07, then halted=1 and pc_out stays 07. Subsequent IF/ID are bubbles. A later branch_taken to 8'h10 resumes fetch at 10.
- PC wrap: start at RESET_PC=8'hFE → ifid_pc sequence FE, FF, 00, 01; no glitch on halted.
- Reset asserted mid-stream with stall=1 and branch_taken=1 → the next edge gives pc=RESET_PC, ifid_valid=0, fetch_count=0, state=BOOT.
